// File: rtl/blackjack_pkg.sv
// Shared card types and dealer FSM states for the blackjack datapath.
// DEALER_AUTO_RESHUFFLE_EN adds the RESHUF state used by card_dealer.
package blackjack_pkg;

  localparam int DECK_SIZE_STD  = 52;
  localparam int RANKS_PER_SUIT = 13;

  typedef enum logic [1:0] {
    HEARTS   = 2'd0,
    DIAMONDS = 2'd1,
    CLUBS    = 2'd2,
    SPADES   = 2'd3
  } suit_t;

  typedef struct packed {
    logic [3:0] rank;
    suit_t      suit;
  } card_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PROBE  = 2'd1,
`ifdef DEALER_AUTO_RESHUFFLE_EN
    ST_DEAL   = 2'd2,
    ST_RESHUF = 2'd3
`else
    ST_DEAL   = 2'd2
`endif
  } dealer_state_t;

endpackage

// File: rtl/card_decode.sv
// Combinational deck index to rank/suit conversion: suit = idx/13,
// rank = (idx mod 13) + 1. Shared with the display and scoring blocks.
module card_decode
  import blackjack_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic [IDX_W-1:0] idx_i,
  output card_t            card_o
);

  localparam int unsigned R = RANKS_PER_SUIT;

  logic [31:0] idx_w;
  logic [1:0]  suit_w;

  assign idx_w = 32'(idx_i);

  // Range compare instead of a divider; the deck never exceeds four suits.
  always_comb begin
    suit_w = 2'd0;
    if (idx_w >= 3 * R)      suit_w = 2'd3;
    else if (idx_w >= 2 * R) suit_w = 2'd2;
    else if (idx_w >= R)     suit_w = 2'd1;
  end

  assign card_o.rank = 4'(idx_w - 32'(suit_w) * R + 32'd1);
  assign card_o.suit = suit_t'(suit_w);

endmodule

// File: rtl/card_dealer.sv
// Deals unique cards from a used-slot bitmap by linear probing from a random index.
// Optional DEALER_AUTO_RESHUFFLE_EN refills the deck on a request when it is empty.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int DECK_SIZE = DECK_SIZE_STD,
  parameter int IDX_W     = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_request,
  input  logic             i_shuffle,
  input  logic [IDX_W-1:0] i_rand,
  output logic [3:0]       o_card_rank,
  output logic [1:0]       o_card_suit,
  output logic             o_card_valid,
  output logic             o_busy,
  output logic [IDX_W-1:0] o_cards_left,
  output logic             o_deck_empty,
  output dealer_state_t    o_dbg_state
);

  // Handshake: i_request is a level sampled only while IDLE (o_busy low);
  // anything else is dropped. o_card_valid is a single-cycle strobe with no
  // back-pressure, aligned with the updated rank/suit and o_cards_left.

  localparam logic [IDX_W-1:0] DECK_N   = IDX_W'(DECK_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DECK_SIZE - 1);
  localparam card_t            NO_CARD  = '{rank: 4'd0, suit: HEARTS};

  dealer_state_t          state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DECK_SIZE-1:0]   used_q, used_d;
  logic [IDX_W-1:0]       left_q, left_d;
  card_t                  card_q, card_d;
  logic                   valid_q, valid_d;
  logic [IDX_W-1:0]       rand_fold;
  card_t                  dec_card;

  // The generator range is below 2*DECK_SIZE, so one subtraction folds it.
  assign rand_fold = (i_rand >= DECK_N) ? (i_rand - DECK_N) : i_rand;

  card_decode #(.IDX_W(IDX_W)) u_decode (
    .idx_i  (idx_q),
    .card_o (dec_card)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    used_d  = used_q;
    left_d  = left_q;
    card_d  = card_q;
    valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_request) begin
          if (left_q != '0) begin
            idx_d   = rand_fold;
            state_d = ST_PROBE;
          end
`ifdef DEALER_AUTO_RESHUFFLE_EN
          else begin
            used_d  = '0;
            left_d  = DECK_N;
            state_d = ST_RESHUF;
          end
`endif
        end
      end
      ST_PROBE: begin
        if (used_q[idx_q]) begin
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end else begin
          state_d = ST_DEAL;
        end
      end
      ST_DEAL: begin
        used_d[idx_q] = 1'b1;
        left_d        = left_q - 1'b1;
        card_d        = dec_card;
        valid_d       = 1'b1;
        state_d       = ST_IDLE;
      end
`ifdef DEALER_AUTO_RESHUFFLE_EN
      ST_RESHUF: begin
        idx_d   = rand_fold;
        state_d = ST_PROBE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Shuffle overrides everything, including a deal about to complete.
    if (i_shuffle) begin
      state_d = ST_IDLE;
      used_d  = '0;
      left_d  = DECK_N;
      card_d  = NO_CARD;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      used_q  <= '0;
      left_q  <= DECK_N;
      card_q  <= NO_CARD;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      used_q  <= used_d;
      left_q  <= left_d;
      card_q  <= card_d;
      valid_q <= valid_d;
    end
  end

  assign o_card_rank  = card_q.rank;
  assign o_card_suit  = card_q.suit;
  assign o_card_valid = valid_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_cards_left = left_q;
  assign o_deck_empty = (left_q == '0);
  assign o_dbg_state  = state_q;

endmodule
